// File: rtl/student_fir_out_pkg.sv
// Shared widths, saturation limits and helpers for the FIR output stage.
// Latency: none (constants and combinational functions only).
// Backpressure: not applicable.
package student_fir_out_pkg;

  localparam int DEF_DATA_IN_W  = 64;
  localparam int DEF_DATA_OUT_W = 16;
  localparam int CNT_W          = 16;

  localparam logic signed [DEF_DATA_OUT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DEF_DATA_OUT_W-1:0] SAT_MIN = 16'sh8000;
  localparam logic [CNT_W-1:0]                 CNT_MAX = '1;

  // Clamp a widened accumulator to the 16-bit sample range; MSB of the result flags a clip
  function automatic logic [DEF_DATA_OUT_W:0] sat16(input logic signed [DEF_DATA_IN_W:0] x);
    logic [DEF_DATA_OUT_W:0] res;
    if (x > (DEF_DATA_IN_W+1)'(SAT_MAX)) begin
      res = {1'b1, SAT_MAX};
    end else if (x < (DEF_DATA_IN_W+1)'(SAT_MIN)) begin
      res = {1'b1, SAT_MIN};
    end else begin
      res = {1'b0, x[DEF_DATA_OUT_W-1:0]};
    end
    return res;
  endfunction

  // Event counter step that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c, input logic ev);
    return (ev && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

endpackage

// File: rtl/student_sync_fifo.sv
// Small synchronous FIFO with show-ahead head data and occupancy count.
// Latency: a push is visible in level and at the head on the next cycle.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
module student_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_dat,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot within the same cycle, so a full FIFO can still accept
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/student_fir_out_conv.sv
// FIR accumulator to 16-bit IIS sample: shift, optional round, saturate, queue, count events.
// Latency: strobe at N enters the FIFO at N+3; request at M answers at M+1.
// Backpressure: none upstream; a full FIFO drops new samples, an empty one repeats the last.
module student_fir_out_conv
  import student_fir_out_pkg::*;
#(
  parameter int DATA_IN_W  = DEF_DATA_IN_W,
  parameter int DATA_OUT_W = DEF_DATA_OUT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_W    = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          fir_valid_i,
  input  logic [DATA_IN_W-1:0]          fir_data_i,
  input  logic [SHIFT_W-1:0]            shift_i,
  input  logic                          round_en_i,
  input  logic                          iis_req_i,
  input  logic                          clr_cnt_i,
  output logic [DATA_OUT_W-1:0]         sample_o,
  output logic                          sample_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [CNT_W-1:0]              sat_cnt_o,
  output logic [CNT_W-1:0]              drop_cnt_o,
  output logic [CNT_W-1:0]              underrun_cnt_o
);

  logic                         s1_vld;
  logic [DATA_IN_W-1:0]         s1_dat;
  logic [SHIFT_W-1:0]           s1_shift;
  logic                         s1_round;
  logic                         s2_vld;
  logic signed [DATA_IN_W:0]    s2_dat;
  logic                         s3_vld;
  logic [DATA_OUT_W-1:0]        s3_dat;

  logic signed [DATA_IN_W:0]    rnd_add;
  logic signed [DATA_IN_W:0]    sum;
  logic signed [DATA_IN_W:0]    shifted;
  logic                         s2_sat;
  logic [DATA_OUT_W-1:0]        s2_clip;

  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [DATA_OUT_W-1:0]        fifo_head;
  logic                         sat_evt;
  logic                         drop_evt;
  logic                         under_evt;

  // Round-half-up offset and arithmetic shift, one bit wider so the offset cannot overflow
  always_comb begin
    rnd_add = '0;
    if (s1_round && (s1_shift != '0)) begin
      rnd_add = (DATA_IN_W+1)'(1) << (s1_shift - SHIFT_W'(1));
    end
    sum     = $signed({s1_dat[DATA_IN_W-1], s1_dat}) + rnd_add;
    shifted = sum >>> s1_shift;
  end

  // Clip the scaled value to the sample range
  always_comb begin
    {s2_sat, s2_clip} = sat16(s2_dat);
  end

  // Three-stage pipeline; data registers only load behind a valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld   <= 1'b0;
      s1_dat   <= '0;
      s1_shift <= '0;
      s1_round <= 1'b0;
      s2_vld   <= 1'b0;
      s2_dat   <= '0;
      s3_vld   <= 1'b0;
      s3_dat   <= '0;
    end else begin
      s1_vld <= fir_valid_i;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      if (fir_valid_i) begin
        s1_dat   <= fir_data_i;
        s1_shift <= shift_i;
        s1_round <= round_en_i;
      end
      if (s1_vld) s2_dat <= shifted;
      if (s2_vld) s3_dat <= s2_clip;
    end
  end

  // An empty FIFO never bypasses a same-cycle push to the requester
  assign fifo_pop  = iis_req_i & ~fifo_empty;
  assign sat_evt   = s2_vld & s2_sat;
  assign drop_evt  = s3_vld & fifo_full & ~fifo_pop;
  assign under_evt = iis_req_i & fifo_empty;

  student_sync_fifo #(
    .DATA_W (DATA_OUT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (s3_vld),
    .push_dat (s3_dat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level_o)
  );

  // Answer every request one cycle later; hold the last sample on underrun
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      sample_valid_o <= iis_req_i;
      if (fifo_pop) sample_o <= fifo_head;
    end
  end

  // Debug event counters; clear beats a coincident increment
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      sat_cnt_o      <= '0;
      drop_cnt_o     <= '0;
      underrun_cnt_o <= '0;
    end else begin
      sat_cnt_o      <= cnt_inc(sat_cnt_o, sat_evt);
      drop_cnt_o     <= cnt_inc(drop_cnt_o, drop_evt);
      underrun_cnt_o <= cnt_inc(underrun_cnt_o, under_evt);
    end
  end

endmodule

// File: tb/tb_student_fir_out_conv.sv
// Self-checking bench for the FIR output stage: directed scenarios plus random traffic.
// Latency: the model tracks strobe-to-FIFO and request-to-sample timing per cycle.
// Backpressure: the model queue mirrors the FIFO drop and underrun rules.
module tb_student_fir_out_conv;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        fir_valid_i = 1'b0;
  logic [63:0] fir_data_i = '0;
  logic [5:0]  shift_i = '0;
  logic        round_en_i = 1'b0;
  logic        iis_req_i = 1'b0;
  logic        clr_cnt_i = 1'b0;
  logic [15:0] sample_o;
  logic        sample_valid_o;
  logic [2:0]  fifo_level_o;
  logic [15:0] sat_cnt_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] underrun_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  student_fir_out_conv dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .fir_valid_i    (fir_valid_i),
    .fir_data_i     (fir_data_i),
    .shift_i        (shift_i),
    .round_en_i     (round_en_i),
    .iis_req_i      (iis_req_i),
    .clr_cnt_i      (clr_cnt_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .fifo_level_o   (fifo_level_o),
    .sat_cnt_o      (sat_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  // Reference model state
  typedef struct packed {
    logic        vld;
    logic        sat;
    logic [15:0] val;
  } stage_t;

  stage_t      m_pipe[$];
  logic [15:0] m_q[$];
  logic [15:0] m_sample;
  logic        m_valid;
  int          m_sat;
  int          m_drop;
  int          m_under;

  // Scaling by floor division on a very wide integer, then clamp
  function automatic logic [16:0] ref_conv(input logic [63:0] d, input int sh, input bit rnd);
    logic signed [127:0] t;
    logic signed [127:0] den;
    logic signed [127:0] q;
    t   = 128'($signed(d));
    den = 128'sd1 <<< sh;
    if (rnd && sh != 0) t = t + (den >>> 1);
    q = t / den;
    if (t < 0 && q * den != t) q = q - 128'sd1;
    if (q > 128'sd32767) return {1'b1, 16'h7FFF};
    if (q < -128'sd32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic model_reset;
    stage_t z;
    z = '0;
    m_pipe.delete();
    repeat (3) m_pipe.push_back(z);
    m_q.delete();
    m_sample = '0;
    m_valid  = 1'b0;
    m_sat    = 0;
    m_drop   = 0;
    m_under  = 0;
  endtask

  // Drive one cycle of inputs, advance the model, step past the clock edge
  task automatic cyc(input bit fv, input logic [63:0] d, input logic [5:0] sh,
                     input bit rnd, input bit req, input bit clr);
    logic [16:0] cv;
    stage_t      nw;
    stage_t      ent;
    stage_t      mid;
    bit          e_sat;
    bit          e_drop;
    bit          e_under;
    fir_valid_i = fv;
    fir_data_i  = d;
    shift_i     = sh;
    round_en_i  = rnd;
    iis_req_i   = req;
    clr_cnt_i   = clr;
    cv = ref_conv(d, int'(sh), rnd);
    nw.vld = fv;
    nw.sat = cv[16];
    nw.val = cv[15:0];
    ent = m_pipe[0];
    mid = m_pipe[1];
    e_sat   = mid.vld && mid.sat;
    e_drop  = 1'b0;
    e_under = 1'b0;
    m_valid = req;
    if (req) begin
      if (m_q.size() > 0) m_sample = m_q.pop_front();
      else e_under = 1'b1;
    end
    if (ent.vld) begin
      if (m_q.size() < 4) m_q.push_back(ent.val);
      else e_drop = 1'b1;
    end
    if (clr) begin
      m_sat = 0; m_drop = 0; m_under = 0;
    end else begin
      if (e_sat && m_sat < 65535) m_sat++;
      if (e_drop && m_drop < 65535) m_drop++;
      if (e_under && m_under < 65535) m_under++;
    end
    void'(m_pipe.pop_front());
    m_pipe.push_back(nw);
    @(posedge clk);
    #1;
    fir_valid_i = 1'b0;
    iis_req_i   = 1'b0;
    clr_cnt_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    rst_i       = 1'b1;
    fir_valid_i = 1'b0;
    iis_req_i   = 1'b0;
    clr_cnt_i   = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset();
    n_tests++;
    if ({sample_o, sample_valid_o, fifo_level_o, sat_cnt_o, drop_cnt_o, underrun_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got sample=%h vld=%b lvl=%0d sat=%0d drop=%0d und=%0d want all 0",
               sample_o, sample_valid_o, fifo_level_o, sat_cnt_o, drop_cnt_o, underrun_cnt_o);
    end
  endtask

  task automatic test_scaling;
    logic [63:0] td [5];
    logic [5:0]  ts [5];
    bit          tr [5];
    logic [15:0] te [5];
    td[0] = 64'h0000_0000_0012_3400; ts[0] = 6'd8; tr[0] = 1'b0; te[0] = 16'h1234;
    td[1] = 64'd384;                 ts[1] = 6'd8; tr[1] = 1'b1; te[1] = 16'd2;
    td[2] = 64'd384;                 ts[2] = 6'd8; tr[2] = 1'b0; te[2] = 16'd1;
    td[3] = -64'sd384;               ts[3] = 6'd8; tr[3] = 1'b1; te[3] = 16'hFFFF;
    td[4] = -64'sd384;               ts[4] = 6'd8; tr[4] = 1'b0; te[4] = 16'hFFFE;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      cyc(1'b1, td[i], ts[i], tr[i], 1'b0, 1'b0);
      idle(3);
      n_tests++;
      if (fifo_level_o !== 3'd1) begin
        n_fail++;
        $display("FAIL scale_level[%0d] got %0d want 1", i, fifo_level_o);
      end
      cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (sample_valid_o !== 1'b1 || sample_o !== te[i]) begin
        n_fail++;
        $display("FAIL scale_sample[%0d] got vld=%b %h want vld=1 %h", i, sample_valid_o, sample_o, te[i]);
      end
      idle(1);
      n_tests++;
      if (sample_valid_o !== 1'b0 || sat_cnt_o !== 16'd0) begin
        n_fail++;
        $display("FAIL scale_after[%0d] got vld=%b sat=%0d want vld=0 sat=0", i, sample_valid_o, sat_cnt_o);
      end
    end
  endtask

  task automatic test_saturation;
    do_reset();
    cyc(1'b1, 64'h0000_0001_0000_0000, 6'd8, 1'b0, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (sample_o !== 16'h7FFF || sat_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL sat_pos got %h sat=%0d want 7fff sat=1", sample_o, sat_cnt_o);
    end
    cyc(1'b1, 64'hFFFF_FF00_0000_0000, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (sample_o !== 16'h8000 || sat_cnt_o !== 16'd2) begin
      n_fail++;
      $display("FAIL sat_neg got %h sat=%0d want 8000 sat=2", sample_o, sat_cnt_o);
    end
  endtask

  task automatic test_drop_underrun;
    logic [15:0] exp_v [5];
    exp_v[0] = 16'd1; exp_v[1] = 16'd2; exp_v[2] = 16'd3; exp_v[3] = 16'd4; exp_v[4] = 16'd4;
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(1'b1, 64'(i), 6'd0, 1'b0, 1'b0, 1'b0);
    idle(4);
    n_tests++;
    if (fifo_level_o !== 3'd4 || drop_cnt_o !== 16'd2) begin
      n_fail++;
      $display("FAIL drop_full got lvl=%0d drop=%0d want lvl=4 drop=2", fifo_level_o, drop_cnt_o);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (sample_valid_o !== 1'b1 || sample_o !== exp_v[i]) begin
        n_fail++;
        $display("FAIL drain[%0d] got vld=%b %h want vld=1 %h", i, sample_valid_o, sample_o, exp_v[i]);
      end
    end
    n_tests++;
    if (underrun_cnt_o !== 16'd1 || fifo_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL underrun got und=%0d lvl=%0d want und=1 lvl=0", underrun_cnt_o, fifo_level_o);
    end
  endtask

  task automatic test_push_pop_same;
    logic [15:0] rest [4];
    rest[0] = 16'd2; rest[1] = 16'd3; rest[2] = 16'd4; rest[3] = 16'd9;
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 64'(i), 6'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'd9, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (sample_o !== 16'd1 || fifo_level_o !== 3'd4 || drop_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL full_pushpop got %h lvl=%0d drop=%0d want 0001 lvl=4 drop=0",
               sample_o, fifo_level_o, drop_cnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (sample_o !== rest[i]) begin
        n_fail++;
        $display("FAIL full_order[%0d] got %h want %h", i, sample_o, rest[i]);
      end
    end
    do_reset();
    cyc(1'b1, 64'd7, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (sample_valid_o !== 1'b1 || sample_o !== 16'd0 || underrun_cnt_o !== 16'd1 || fifo_level_o !== 3'd1) begin
      n_fail++;
      $display("FAIL empty_pushpop got vld=%b %h und=%0d lvl=%0d want vld=1 0000 und=1 lvl=1",
               sample_valid_o, sample_o, underrun_cnt_o, fifo_level_o);
    end
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (sample_o !== 16'd7) begin
      n_fail++;
      $display("FAIL empty_queued got %h want 0007", sample_o);
    end
  endtask

  task automatic test_reset_midop;
    do_reset();
    for (int i = 11; i <= 13; i++) cyc(1'b1, 64'(i), 6'd0, 1'b0, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (sample_o !== 16'd11 || fifo_level_o !== 3'd2) begin
      n_fail++;
      $display("FAIL midop_pre got %h lvl=%0d want 000b lvl=2", sample_o, fifo_level_o);
    end
    for (int i = 21; i <= 23; i++) cyc(1'b1, 64'(i), 6'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({sample_o, sample_valid_o, fifo_level_o, sat_cnt_o, drop_cnt_o, underrun_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset got sample=%h vld=%b lvl=%0d sat=%0d drop=%0d und=%0d want all 0",
               sample_o, sample_valid_o, fifo_level_o, sat_cnt_o, drop_cnt_o, underrun_cnt_o);
    end
    rst_i = 1'b0;
    model_reset();
    idle(5);
    n_tests++;
    if (fifo_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL midop_flush got lvl=%0d want 0", fifo_level_o);
    end
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (sample_valid_o !== 1'b1 || sample_o !== 16'd0 || underrun_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL midop_req got vld=%b %h und=%0d want vld=1 0000 und=1",
               sample_valid_o, sample_o, underrun_cnt_o);
    end
  endtask

  task automatic test_clr_during_sat;
    do_reset();
    cyc(1'b1, 64'h0000_0001_0000_0000, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
    n_tests++;
    if (sat_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_pre got sat=%0d want 1", sat_cnt_o);
    end
    cyc(1'b1, 64'h0000_0001_0000_0000, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    idle(3);
    n_tests++;
    if (sat_cnt_o !== 16'd0 || fifo_level_o !== 3'd2) begin
      n_fail++;
      $display("FAIL clr_sat got sat=%0d lvl=%0d want sat=0 lvl=2", sat_cnt_o, fifo_level_o);
    end
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic [5:0]  sh;
    bit          fv;
    bit          rnd;
    bit          req;
    bit          clr;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      fv  = bit'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      d   = $signed(d) >>> $urandom_range(0, 63);
      sh  = 6'($urandom_range(0, 63));
      rnd = bit'($urandom_range(0, 1));
      req = ($urandom_range(0, 99) < 40);
      clr = ($urandom_range(0, 99) < 2);
      cyc(fv, d, sh, rnd, req, clr);
      n_tests++;
      if (sample_valid_o !== m_valid || sample_o !== m_sample || fifo_level_o !== 3'(m_q.size())) begin
        n_fail++;
        $display("FAIL rand[%0d] got vld=%b %h lvl=%0d want vld=%b %h lvl=%0d",
                 i, sample_valid_o, sample_o, fifo_level_o, m_valid, m_sample, m_q.size());
      end
    end
    idle(6);
    n_tests++;
    if (sat_cnt_o !== 16'(m_sat) || drop_cnt_o !== 16'(m_drop) || underrun_cnt_o !== 16'(m_under)) begin
      n_fail++;
      $display("FAIL rand_cnt got sat=%0d drop=%0d und=%0d want sat=%0d drop=%0d und=%0d",
               sat_cnt_o, drop_cnt_o, underrun_cnt_o, m_sat, m_drop, m_under);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scaling();
    test_saturation();
    test_drop_underrun();
    test_push_pop_same();
    test_reset_midop();
    test_clr_during_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
